// File: rtl/az_sequencer.sv
// ---------------------------------------------------------------------------
// az_sequencer
//
// Purpose: sequences ADC measurements for an auto-zero front end. Each
// measurement is settle -> trigger -> wait-for-valid. With az_en set, the
// input mux alternates between the signal input (azmux=1) and the zero/LO
// input (azmux=0); otherwise only the signal input is measured.
//
// Optional feature: define AZ_SEQ_WATCHDOG_EN to enable the WAIT-state
// watchdog. It moves the sequencer to ERR (sticky err) after TIMEOUT_CYCLES
// cycles without a valid. Without the macro, WAIT waits forever and err is 0.
//
// Ports:
//   clk                  system clock, all logic on posedge
//   reset                synchronous active-high reset
//   run                  level: 1 = sequence measurements, 0 = go to IDLE
//   az_en                1 = alternate signal/zero phases, 0 = signal only
//   clk_settle_duration  mux settle count, loaded on each SETTLE entry
//   adc_measure_valid    ADC level, high when its measurement is complete
//   adc_measure_trig     one-cycle pulse that starts an ADC measurement
//   azmux                1 = signal input, 0 = zero/LO input
//   sample_valid         one-cycle pulse per completed measurement
//   sample_phase         azmux value of the measurement behind sample_valid
//   sample_count         completed-measurement counter (wraps, reset-only clear)
//   err                  sticky watchdog error flag
//   monitor              registered taps {idle, err, sample_valid, azmux,
//                        adc_measure_valid, adc_measure_trig}
// ---------------------------------------------------------------------------
module az_sequencer #(
  parameter int CNT_W          = 32,
  parameter int TIMEOUT_CYCLES = 10_000_000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             az_en,
  input  logic [CNT_W-1:0] clk_settle_duration,
  input  logic             adc_measure_valid,
  output logic             adc_measure_trig,
  output logic             azmux,
  output logic             sample_valid,
  output logic             sample_phase,
  output logic [15:0]      sample_count,
  output logic             err,
  output logic [5:0]       monitor
);

`ifdef AZ_SEQ_WATCHDOG_EN
  localparam logic WDOG_EN = 1'b1;
`else
  localparam logic WDOG_EN = 1'b0;
`endif

  // Last counter value of a WAIT before the watchdog fires, so that ERR is
  // entered after exactly TIMEOUT_CYCLES WAIT cycles.
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE_HI,
    S_TRIG_HI,
    S_WAIT_HI,
    S_SETTLE_LO,
    S_TRIG_LO,
    S_WAIT_LO,
    S_ERR
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_settle_cnt;
  logic [CNT_W-1:0] r_tmo_cnt;
  logic             r_wait_first;
  logic             r_trig;
  logic             r_azmux;
  logic             r_sample_valid;
  logic             r_sample_phase;
  logic [15:0]      r_sample_count;
  logic             r_err;
  logic [5:0]       r_monitor;

  state_t           w_state_next;
  logic [CNT_W-1:0] w_settle_next;
  logic [CNT_W-1:0] w_tmo_next;
  logic             w_wait_first_next;
  logic             w_trig_next;
  logic             w_azmux_next;
  logic             w_sample_valid_next;
  logic             w_sample_phase_next;
  logic [15:0]      w_sample_count_next;
  logic             w_err_next;
  logic             w_accept;

  // The first WAIT cycle is blind: the ADC needs one cycle to drop a stale
  // valid left over from the previous conversion.
  assign w_accept = adc_measure_valid && !r_wait_first;

  always_comb begin
    w_state_next        = r_state;
    w_settle_next       = r_settle_cnt;
    w_tmo_next          = r_tmo_cnt;
    w_wait_first_next   = 1'b0;
    w_trig_next         = 1'b0;
    w_azmux_next        = r_azmux;
    w_sample_valid_next = 1'b0;
    w_sample_phase_next = r_sample_phase;
    w_sample_count_next = r_sample_count;
    w_err_next          = r_err;

    if (!run) begin
      // Dropping run wins over everything, including a valid this cycle.
      w_state_next = S_IDLE;
      w_azmux_next = 1'b0;
      w_err_next   = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_state_next  = S_SETTLE_HI;
          w_azmux_next  = 1'b1;
          w_settle_next = clk_settle_duration;
        end

        S_SETTLE_HI, S_SETTLE_LO: begin
          if (r_settle_cnt == '0) begin
            w_state_next = (r_state == S_SETTLE_HI) ? S_TRIG_HI : S_TRIG_LO;
            w_trig_next  = 1'b1;
            w_tmo_next   = '0;
          end else begin
            w_settle_next = r_settle_cnt - CNT_W'(1);
          end
        end

        S_TRIG_HI: begin
          w_state_next      = S_WAIT_HI;
          w_wait_first_next = 1'b1;
        end

        S_TRIG_LO: begin
          w_state_next      = S_WAIT_LO;
          w_wait_first_next = 1'b1;
        end

        S_WAIT_HI, S_WAIT_LO: begin
          if (w_accept) begin
            w_sample_valid_next = 1'b1;
            w_sample_phase_next = r_azmux;
            w_sample_count_next = r_sample_count + 16'd1;
            w_settle_next       = clk_settle_duration;
            // az_en only matters when leaving the signal phase.
            if (r_state == S_WAIT_HI && az_en) begin
              w_state_next = S_SETTLE_LO;
              w_azmux_next = 1'b0;
            end else begin
              w_state_next = S_SETTLE_HI;
              w_azmux_next = 1'b1;
            end
          end else if (WDOG_EN && (r_tmo_cnt == TMO_LAST)) begin
            w_state_next = S_ERR;
            w_err_next   = 1'b1;
            w_azmux_next = 1'b0;
          end else begin
            w_tmo_next = r_tmo_cnt + CNT_W'(1);
          end
        end

        S_ERR: begin
          w_state_next = S_ERR;
        end

        default: begin
          w_state_next = S_IDLE;
          w_azmux_next = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_settle_cnt   <= '0;
      r_tmo_cnt      <= '0;
      r_wait_first   <= 1'b0;
      r_trig         <= 1'b0;
      r_azmux        <= 1'b0;
      r_sample_valid <= 1'b0;
      r_sample_phase <= 1'b0;
      r_sample_count <= 16'd0;
      r_err          <= 1'b0;
      r_monitor      <= 6'd0;
    end else begin
      r_state        <= w_state_next;
      r_settle_cnt   <= w_settle_next;
      r_tmo_cnt      <= w_tmo_next;
      r_wait_first   <= w_wait_first_next;
      r_trig         <= w_trig_next;
      r_azmux        <= w_azmux_next;
      r_sample_valid <= w_sample_valid_next;
      r_sample_phase <= w_sample_phase_next;
      r_sample_count <= w_sample_count_next;
      r_err          <= w_err_next;
      r_monitor      <= {(r_state == S_IDLE), r_err, r_sample_valid,
                         r_azmux, adc_measure_valid, r_trig};
    end
  end

  assign adc_measure_trig = r_trig;
  assign azmux            = r_azmux;
  assign sample_valid     = r_sample_valid;
  assign sample_phase     = r_sample_phase;
  assign sample_count     = r_sample_count;
  assign err              = r_err;
  assign monitor          = r_monitor;

endmodule

// File: tb/tb_az_sequencer.sv
// ---------------------------------------------------------------------------
// tb_az_sequencer
//
// Directed sequence of scenarios with randomized ADC latencies. Expected
// trigger and sample times are computed up front from the timing rules:
//   first trig at cycle d+2 after run is raised,
//   sample_valid at trig + k + 1 (ADC valid k cycles after trig, k >= 2),
//   next trig at sample + d + 1,
// with phases alternating when az_en=1. A small ADC model drives valid.
// ---------------------------------------------------------------------------
module tb_az_sequencer;
  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic             run;
  logic             az_en;
  logic [CNT_W-1:0] dur;
  logic             adc_measure_valid;
  logic             adc_measure_trig;
  logic             azmux;
  logic             sample_valid;
  logic             sample_phase;
  logic [15:0]      sample_count;
  logic             err;
  logic [5:0]       monitor;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_count;

  az_sequencer #(.CNT_W(CNT_W), .TIMEOUT_CYCLES(100)) dut (
    .clk                 (clk),
    .reset               (reset),
    .run                 (run),
    .az_en               (az_en),
    .clk_settle_duration (dur),
    .adc_measure_valid   (adc_measure_valid),
    .adc_measure_trig    (adc_measure_trig),
    .azmux               (azmux),
    .sample_valid        (sample_valid),
    .sample_phase        (sample_phase),
    .sample_count        (sample_count),
    .err                 (err),
    .monitor             (monitor)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit phase_of(input bit az, input int idx);
    return az ? (idx % 2 == 0) : 1'b1;
  endfunction

  // Runs n complete measurements, then drops run in the very cycle the ADC
  // raises valid for measurement n+1 (that sample must be lost).
  task automatic run_seq(input int d, input bit az, input int n, input bit stale, input int kfix);
    int   k[$];
    int   tq[$];
    int   sq[$];
    int   t;
    int   done;
    int   ntrig;
    int   last_t;
    int   kk;
    int   abort_c;
    bit   have_t;
    bit   p_idle, p_sv, p_az, p_valid, p_trig;
    bit   e_trig, e_sv, e_az;
    logic [5:0] e_mon;

    for (int i = 0; i <= n; i++)
      k.push_back(kfix != 0 ? kfix : (stale ? int'($urandom_range(3, 7)) : int'($urandom_range(2, 7))));
    t = d + 2;
    for (int i = 0; i <= n; i++) begin
      tq.push_back(t);
      if (i < n) sq.push_back(t + k[i] + 1);
      t += k[i] + d + 2;
    end
    abort_c = tq[n] + k[n];

    dur   = CNT_W'(d);
    az_en = az;
    run   = 1'b1;
    p_idle = 1'b1; p_sv = 1'b0; p_az = 1'b0; p_valid = adc_measure_valid; p_trig = 1'b0;
    done = 0; ntrig = 0; last_t = 0; have_t = 1'b0;

    for (int c = 1; c <= abort_c; c++) begin
      step();
      e_trig = (tq.size() > 0 && tq[0] == c);
      if (e_trig) void'(tq.pop_front());
      e_sv = (sq.size() > 0 && sq[0] == c);
      if (e_sv) begin
        void'(sq.pop_front());
        done++;
        exp_count = exp_count + 16'd1;
      end
      chk("trig", 32'(adc_measure_trig), 32'(e_trig));
      chk("sample_valid", 32'(sample_valid), 32'(e_sv));
      chk("sample_count", 32'(sample_count), 32'(exp_count));
      if (e_sv) begin
        chk("sample_phase", 32'(sample_phase), 32'(phase_of(az, done - 1)));
        $display("sample: cycle=%0d phase=%0d count=%04h", c, sample_phase, sample_count);
      end
      e_az = phase_of(az, done);
      chk("azmux", 32'(azmux), 32'(e_az));
      e_mon = {p_idle, 1'b0, p_sv, p_az, p_valid, p_trig};
      chk("monitor", 32'(monitor), 32'(e_mon));
      chk("err", 32'(err), 32'd0);

      // ADC model: reacts to the trigger it actually sees.
      if (adc_measure_trig) begin
        have_t = 1'b1;
        last_t = c;
        ntrig++;
      end else if (have_t) begin
        kk = (ntrig - 1 <= n) ? k[ntrig - 1] : 2;
        if (c < last_t + kk) adc_measure_valid = stale && (c == last_t + 1);
        else                 adc_measure_valid = 1'b1;
      end
      if (c == abort_c) run = 1'b0;

      p_idle = 1'b0; p_sv = e_sv; p_az = e_az; p_valid = adc_measure_valid; p_trig = e_trig;
    end

    step();
    chk("abort_sample_valid", 32'(sample_valid), 32'd0);
    chk("abort_trig", 32'(adc_measure_trig), 32'd0);
    chk("abort_azmux", 32'(azmux), 32'd0);
    chk("abort_count", 32'(sample_count), 32'(exp_count));
    for (int i = 0; i < 3; i++) begin
      adc_measure_valid = 1'($urandom);
      step();
      chk("idle_sample_valid", 32'(sample_valid), 32'd0);
      chk("idle_trig", 32'(adc_measure_trig), 32'd0);
      chk("idle_azmux", 32'(azmux), 32'd0);
      chk("idle_count", 32'(sample_count), 32'(exp_count));
      chk("idle_monitor_idle", 32'(monitor[5]), 32'd1);
    end
    adc_measure_valid = 1'b0;
    step();
  endtask

  initial begin
    reset = 1'b1; run = 1'b0; az_en = 1'b0; dur = '0; adc_measure_valid = 1'b0;
    exp_count = 16'd0;
    step(); step();
    chk("rst_trig", 32'(adc_measure_trig), 32'd0);
    chk("rst_azmux", 32'(azmux), 32'd0);
    chk("rst_sample_valid", 32'(sample_valid), 32'd0);
    chk("rst_sample_phase", 32'(sample_phase), 32'd0);
    chk("rst_count", 32'(sample_count), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_monitor", 32'(monitor), 32'd0);
    reset = 1'b0;
    step(); step();

    // Scenario 1: az_en=1, duration=3, ADC valid 10 cycles after trig.
    run_seq(3, 1'b1, 3, 1'b0, 10);
    // Scenario 2: signal phase only, minimal settle.
    run_seq(0, 1'b0, 4, 1'b0, 0);
    // Scenario 3: stale valid held over trigger and the first WAIT cycle.
    adc_measure_valid = 1'b1;
    step();
    run_seq(2, 1'b1, 3, 1'b1, 0);
    // Randomized mixes.
    for (int r = 0; r < 4; r++)
      run_seq(int'($urandom_range(0, 5)), 1'($urandom), int'($urandom_range(1, 4)), 1'($urandom), 0);

    // Scenario 5: counter wrap 0xFFFF -> 0x0000.
    force dut.r_sample_count = 16'hFFFE;
    step();
    release dut.r_sample_count;
    step();
    exp_count = 16'hFFFE;
    chk("preload_count", 32'(sample_count), 32'h0000FFFE);
    run_seq(1, 1'b1, 3, 1'b0, 0);
    chk("wrapped_count", 32'(sample_count), 32'h00000001);

    // Reset in the middle of a measurement, together with a valid.
    dur = CNT_W'(1); az_en = 1'b1; run = 1'b1;
    step(); step(); step();
    chk("mid_trig", 32'(adc_measure_trig), 32'd1);
    step();
    adc_measure_valid = 1'b1;
    step();
    reset = 1'b1; run = 1'b0;
    step();
    exp_count = 16'd0;
    chk("midrst_sample_valid", 32'(sample_valid), 32'd0);
    chk("midrst_count", 32'(sample_count), 32'd0);
    chk("midrst_azmux", 32'(azmux), 32'd0);
    chk("midrst_monitor", 32'(monitor), 32'd0);
    reset = 1'b0; adc_measure_valid = 1'b0;
    step();
    chk("postrst_sample_valid", 32'(sample_valid), 32'd0);
    step();

    // Scenario 6: ADC never answers.
    dur = CNT_W'(1); az_en = 1'b1; run = 1'b1;
    for (int c = 1; c <= 103; c++) step();
    chk("wd_err_before", 32'(err), 32'd0);
    step();
`ifdef AZ_SEQ_WATCHDOG_EN
    chk("wd_err_set", 32'(err), 32'd1);
    chk("wd_azmux", 32'(azmux), 32'd0);
    for (int c = 0; c < 20; c++) step();
    chk("wd_err_sticky", 32'(err), 32'd1);
`else
    chk("wd_err_off", 32'(err), 32'd0);
    chk("wd_azmux_wait", 32'(azmux), 32'd1);
    for (int c = 0; c < 200; c++) step();
    chk("wd_err_off_long", 32'(err), 32'd0);
    chk("wd_trig_off_long", 32'(adc_measure_trig), 32'd0);
`endif
    run = 1'b0;
    step();
    chk("wd_err_cleared", 32'(err), 32'd0);
    chk("wd_azmux_idle", 32'(azmux), 32'd0);
    chk("wd_count", 32'(sample_count), 32'(exp_count));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
